// File: rtl/key_debounce_repeat_if.sv
`default_nettype none
// ============================================================================
// Module   : key_debounce_repeat_if
// Brief    : Key-pin / conditioned-key bundle between board pins and the PIO.
// Revision : 1.0 - initial release
// ============================================================================
interface key_debounce_repeat_if #(
  parameter int NUM_KEYS = 4
);
  logic [NUM_KEYS-1:0] KEYS;
  logic [NUM_KEYS-1:0] repeat_en;
  logic [NUM_KEYS-1:0] key_level_n;
  logic [NUM_KEYS-1:0] press_pulse;
  logic                any_pressed;

  modport master (
    output KEYS, repeat_en,
    input  key_level_n, press_pulse, any_pressed
  );

  modport slave (
    input  KEYS, repeat_en,
    output key_level_n, press_pulse, any_pressed
  );
endinterface
`default_nettype wire

// File: rtl/key_debounce_repeat.sv
`default_nettype none
// ============================================================================
// Module   : key_debounce_repeat
// Brief    : Per-key synchroniser, counter debounce, press pulse and auto-repeat.
// Revision : 1.0 - initial release
// ============================================================================
module key_debounce_repeat #(
  parameter int NUM_KEYS        = 4,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 24,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  wire logic           CLOCK_50,
  input  wire logic           KEY_RS,
  key_debounce_repeat_if.slave keys_bus
);

  localparam logic [CNT_W-1:0] c_deb_last = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_dly_last = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] c_per_last = CNT_W'(REPEAT_PERIOD - 1);

  localparam logic [1:0] c_st_idle   = 2'd0;
  localparam logic [1:0] c_st_delay  = 2'd1;
  localparam logic [1:0] c_st_repeat = 2'd2;

  logic [NUM_KEYS-1:0] w_level_nxt;
  logic                r_any;

  generate
    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
      logic             r_s1, r_s2;
      logic             r_lvl, w_lvl_nxt;
      logic             r_pul;
      logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
      logic [1:0]       r_state, w_state_nxt;
      logic [CNT_W-1:0] r_rcnt, w_rcnt_nxt;
      logic             w_press_edge;
      logic             w_rep_pulse;
      logic             w_en;

      assign w_en = keys_bus.repeat_en[i];

      always_ff @(posedge CLOCK_50) begin
        if (!KEY_RS) begin
          r_s1 <= 1'b1;
          r_s2 <= 1'b1;
        end else begin
          r_s1 <= keys_bus.KEYS[i];
          r_s2 <= r_s1;
        end
      end

      // Any cycle of agreement with the accepted level restarts the count.
      always_comb begin
        w_lvl_nxt = r_lvl;
        w_cnt_nxt = '0;
        if (r_s2 != r_lvl) begin
          if (r_cnt == c_deb_last) begin
            w_lvl_nxt = r_s2;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
      end

      assign w_press_edge   = r_lvl & ~w_lvl_nxt;
      assign w_level_nxt[i] = w_lvl_nxt;

      always_ff @(posedge CLOCK_50) begin
        if (!KEY_RS) begin
          r_lvl   <= 1'b1;
          r_cnt   <= '0;
          r_pul   <= 1'b0;
          r_state <= c_st_idle;
          r_rcnt  <= '0;
        end else begin
          r_lvl   <= w_lvl_nxt;
          r_cnt   <= w_cnt_nxt;
          r_pul   <= w_press_edge | w_rep_pulse;
          r_state <= w_state_nxt;
          r_rcnt  <= w_rcnt_nxt;
        end
      end

      // Release or disable wins over a terminal count in the same cycle.
      always_comb begin
        w_state_nxt = r_state;
        w_rcnt_nxt  = r_rcnt;
        case (r_state)
          c_st_idle: begin
            if (w_press_edge && w_en) begin
              w_state_nxt = c_st_delay;
              w_rcnt_nxt  = '0;
            end
          end
          c_st_delay: begin
            if (w_lvl_nxt || !w_en) begin
              w_state_nxt = c_st_idle;
              w_rcnt_nxt  = '0;
            end else if (r_rcnt == c_dly_last) begin
              w_state_nxt = c_st_repeat;
              w_rcnt_nxt  = '0;
            end else begin
              w_rcnt_nxt  = r_rcnt + 1'b1;
            end
          end
          c_st_repeat: begin
            if (w_lvl_nxt || !w_en) begin
              w_state_nxt = c_st_idle;
              w_rcnt_nxt  = '0;
            end else if (r_rcnt == c_per_last) begin
              w_rcnt_nxt  = '0;
            end else begin
              w_rcnt_nxt  = r_rcnt + 1'b1;
            end
          end
          default: begin
            w_state_nxt = c_st_idle;
            w_rcnt_nxt  = '0;
          end
        endcase
      end

      always_comb begin
        w_rep_pulse = 1'b0;
        case (r_state)
          c_st_delay:  w_rep_pulse = !w_lvl_nxt && w_en && (r_rcnt == c_dly_last);
          c_st_repeat: w_rep_pulse = !w_lvl_nxt && w_en && (r_rcnt == c_per_last);
          default:     w_rep_pulse = 1'b0;
        endcase
      end

      assign keys_bus.key_level_n[i] = r_lvl;
      assign keys_bus.press_pulse[i] = r_pul;
    end
  endgenerate

  always_ff @(posedge CLOCK_50) begin
    if (!KEY_RS) begin
      r_any <= 1'b0;
    end else begin
      r_any <= |(~w_level_nxt);
    end
  end

  assign keys_bus.any_pressed = r_any;

endmodule
`default_nettype wire

// File: tb/tb_key_debounce_repeat.sv
`default_nettype none
// ============================================================================
// Module   : tb_key_debounce_repeat
// Brief    : Self-checking bench with a rule-level reference model of the keys.
// Revision : 1.0 - initial release
// ============================================================================
module tb_key_debounce_repeat;

  localparam int D  = 4;
  localparam int RD = 10;
  localparam int RP = 3;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  key_debounce_repeat_if #(.NUM_KEYS(4)) bus ();

  key_debounce_repeat #(
    .NUM_KEYS(4), .DEBOUNCE_CYCLES(D), .CNT_W(8),
    .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (
    .CLOCK_50 (clk),
    .KEY_RS   (rst_n),
    .keys_bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a level flips once the synchronised pin has disagreed
  // with it for D consecutive edges; pulses at press age 0, RD, RD+k*RP.
  int         n;
  int         m_since[4];
  int         m_press_at[4];
  bit         m_rep_ok[4];
  logic [3:0] m_lvl, m_pul, m_p0, m_p1;
  logic       m_any;

  task automatic tick();
    logic [3:0] syn;
    int age;
    @(posedge clk);
    n++;
    if (!rst_n) begin
      m_lvl = 4'hF; m_pul = 4'h0; m_p0 = 4'hF; m_p1 = 4'hF;
      for (int k = 0; k < 4; k++) begin
        m_since[k] = n; m_rep_ok[k] = 1'b0;
      end
    end else begin
      syn  = m_p1;
      m_p1 = m_p0;
      m_p0 = bus.KEYS;
      for (int k = 0; k < 4; k++) begin
        m_pul[k] = 1'b0;
        if (syn[k] == m_lvl[k]) begin
          m_since[k] = n;
        end else if (n - m_since[k] == D) begin
          m_lvl[k] = syn[k];
          m_since[k] = n;
          if (!syn[k]) begin
            m_pul[k] = 1'b1; m_press_at[k] = n; m_rep_ok[k] = bus.repeat_en[k];
          end else begin
            m_rep_ok[k] = 1'b0;
          end
        end
        if (!m_pul[k] && m_rep_ok[k] && !m_lvl[k]) begin
          if (!bus.repeat_en[k]) begin
            m_rep_ok[k] = 1'b0;
          end else begin
            age = n - m_press_at[k];
            if (age == RD || (age > RD && (age - RD) % RP == 0)) m_pul[k] = 1'b1;
          end
        end
      end
    end
    m_any = |(~m_lvl);
    @(negedge clk);
  endtask

  task automatic settle();
    bus.KEYS = 4'hF;
    repeat (12) tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; bus.KEYS = 4'hF; bus.repeat_en = 4'h0;
    repeat (3) tick();
    checks++;
    if (bus.key_level_n !== 4'hF || bus.press_pulse !== 4'h0 || bus.any_pressed !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: level=%b pulse=%b any=%b expected 1111 0000 0", bus.key_level_n, bus.press_pulse, bus.any_pressed);
    end
    rst_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      tick();
      checks++;
      if (bus.key_level_n !== 4'hF || bus.press_pulse !== 4'h0 || bus.any_pressed !== 1'b0) begin
        errors++;
        $display("FAIL idle_hold c=%0d: level=%b pulse=%b any=%b expected 1111 0000 0", c, bus.key_level_n, bus.press_pulse, bus.any_pressed);
      end
    end
  endtask

  task automatic test_clean_press();
    settle();
    bus.KEYS[0] = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      tick();
      checks++;
      if (bus.key_level_n[0] !== (c < 6) || bus.press_pulse[0] !== (c == 6) || bus.any_pressed !== (c >= 6)) begin
        errors++;
        $display("FAIL clean_press c=%0d: level0=%b pulse0=%b any=%b expected %b %b %b", c,
                 bus.key_level_n[0], bus.press_pulse[0], bus.any_pressed, c < 6, c == 6, c >= 6);
      end
    end
  endtask

  task automatic test_bounce();
    logic [7:0] pat;
    int pulses;
    pat = 8'b0000_1000; // element j is bit j: 0,0,0,1,0,0,0,0
    pulses = 0;
    settle();
    for (int c = 1; c <= 20; c++) begin
      bus.KEYS[1] = (c <= 8) ? pat[c-1] : 1'b0;
      tick();
      if (bus.press_pulse[1] === 1'b1) pulses++;
      if (c == 9 || c == 10) begin
        checks++;
        if (bus.key_level_n[1] !== (c == 9)) begin
          errors++;
          $display("FAIL bounce_fall c=%0d: level1=%b expected %b", c, bus.key_level_n[1], c == 9);
        end
      end
      checks++;
      if (bus.key_level_n !== m_lvl || bus.press_pulse !== m_pul || bus.any_pressed !== m_any) begin
        errors++;
        $display("FAIL bounce_model c=%0d: level=%b pulse=%b any=%b expected %b %b %b", c,
                 bus.key_level_n, bus.press_pulse, bus.any_pressed, m_lvl, m_pul, m_any);
      end
    end
    checks++;
    if (pulses != 1) begin
      errors++;
      $display("FAIL bounce_pulses: got %0d expected 1", pulses);
    end
  endtask

  task automatic test_repeat();
    logic exp;
    settle();
    bus.repeat_en = 4'b0100;
    bus.KEYS[2] = 1'b0;
    for (int c = 1; c <= 22; c++) begin
      tick();
      exp = (c == 6 || c == 16 || c == 19 || c == 22);
      checks++;
      if (bus.press_pulse[2] !== exp || bus.key_level_n[2] !== (c < 6)) begin
        errors++;
        $display("FAIL repeat_held c=%0d: pulse2=%b level2=%b expected %b %b", c, bus.press_pulse[2], bus.key_level_n[2], exp, c < 6);
      end
    end
    // Released right after a repeat: one more lands during the release
    // debounce, the one that would coincide with the release edge is dropped.
    bus.KEYS[2] = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      tick();
      checks++;
      if (bus.press_pulse[2] !== (c == 3) || bus.key_level_n[2] !== (c >= 6)) begin
        errors++;
        $display("FAIL repeat_release c=%0d: pulse2=%b level2=%b expected %b %b", c, bus.press_pulse[2], bus.key_level_n[2], c == 3, c >= 6);
      end
    end
  endtask

  task automatic test_repeat_cancel();
    settle();
    bus.repeat_en = 4'b0100;
    bus.KEYS[2] = 1'b0;
    for (int c = 1; c <= 45; c++) begin
      if (c == 11) bus.repeat_en[2] = 1'b0;
      if (c == 30) bus.repeat_en[2] = 1'b1;
      tick();
      checks++;
      if (bus.press_pulse[2] !== (c == 6) || bus.key_level_n[2] !== (c < 6)) begin
        errors++;
        $display("FAIL repeat_cancel c=%0d: pulse2=%b level2=%b expected %b %b", c, bus.press_pulse[2], bus.key_level_n[2], c == 6, c < 6);
      end
    end
    bus.repeat_en = 4'h0;
  endtask

  task automatic test_reset_mid();
    int pulses;
    pulses = 0;
    settle();
    bus.KEYS[3] = 1'b0;
    repeat (17) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checks++;
    if (bus.key_level_n !== 4'hF || bus.press_pulse !== 4'h0 || bus.any_pressed !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: level=%b pulse=%b any=%b expected 1111 0000 0", bus.key_level_n, bus.press_pulse, bus.any_pressed);
    end
    for (int c = 1; c <= 15; c++) begin
      tick();
      if (bus.press_pulse[3] === 1'b1) pulses++;
      checks++;
      if (bus.key_level_n !== m_lvl || bus.press_pulse !== m_pul || bus.any_pressed !== m_any) begin
        errors++;
        $display("FAIL reset_reaccept c=%0d: level=%b pulse=%b any=%b expected %b %b %b", c,
                 bus.key_level_n, bus.press_pulse, bus.any_pressed, m_lvl, m_pul, m_any);
      end
    end
    checks++;
    if (pulses != 1 || bus.key_level_n[3] !== 1'b0) begin
      errors++;
      $display("FAIL reset_pulses: got %0d level3=%b expected 1 0", pulses, bus.key_level_n[3]);
    end
  endtask

  task automatic test_random();
    settle();
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < 4; k++) begin
        if ($urandom_range(11) == 0) bus.KEYS[k] = ~bus.KEYS[k];
        if ($urandom_range(39) == 0) bus.repeat_en[k] = ~bus.repeat_en[k];
      end
      rst_n = ($urandom_range(499) != 0);
      tick();
      checks++;
      if (bus.key_level_n !== m_lvl || bus.press_pulse !== m_pul || bus.any_pressed !== m_any) begin
        errors++;
        $display("FAIL random c=%0d: level=%b pulse=%b any=%b expected %b %b %b", c,
                 bus.key_level_n, bus.press_pulse, bus.any_pressed, m_lvl, m_pul, m_any);
      end
    end
    rst_n = 1'b1;
  endtask

  initial begin
    errors = 0; checks = 0; n = 0;
    m_lvl = 4'hF; m_pul = 4'h0; m_p0 = 4'hF; m_p1 = 4'hF; m_any = 1'b0;
    for (int k = 0; k < 4; k++) begin
      m_since[k] = 0; m_press_at[k] = 0; m_rep_ok[k] = 1'b0;
    end
    rst_n = 1'b0; bus.KEYS = 4'hF; bus.repeat_en = 4'h0;
    @(negedge clk);
    test_reset();
    test_clean_press();
    test_bounce();
    test_repeat();
    test_repeat_cancel();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
